// File: rtl/pipe_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_sequencer
//  Description : Power-up and run-time sequencer for the camera -> preprocess
//                -> frame-buffer -> display pipeline. Holds off after reset,
//                starts OV7670 configuration, waits for a configuration-done
//                rising edge, discards settling frames and then releases the
//                pipeline. Mode / Gaussian changes are applied only on a frame
//                boundary and are bracketed by a fixed-length pipeline flush.
//                A frame-start watchdog restarts configuration when frames
//                stop arriving.
//  Ports       : i_sysclk          system clock
//                db_rstn           asynchronous active-low reset
//                i_sof             start-of-frame pulse
//                i_cfg_done        configuration-complete level
//                i_mode_toggle     colour/greyscale toggle request pulse
//                i_gaussian_req    raw Gaussian switch (asynchronous)
//                o_cfg_start       configuration start pulse
//                o_mode            applied mode (0 colour, 1 greyscale)
//                o_gaussian_enable applied Gaussian enable
//                o_pipe_flush      pipeline flush
//                o_running         high only while in RUN
//                o_state           current state encoding
//                o_recover_count   saturating watchdog/timeout recovery count
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_sequencer #(
    parameter int POR_CYCLES    = 1250000,
    parameter int CFG_TIMEOUT   = 125000000,
    parameter int WDT_CYCLES    = 12500000,
    parameter int FLUSH_CYCLES  = 64,
    parameter int SETTLE_FRAMES = 2,
    parameter int CNT_W         = 27
) (
    input  logic       i_sysclk,
    input  logic       db_rstn,
    input  logic       i_sof,
    input  logic       i_cfg_done,
    input  logic       i_mode_toggle,
    input  logic       i_gaussian_req,
    output logic       o_cfg_start,
    output logic       o_mode,
    output logic       o_gaussian_enable,
    output logic       o_pipe_flush,
    output logic       o_running,
    output logic [2:0] o_state,
    output logic [7:0] o_recover_count
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CFG_START = 3'd1,
        ST_CFG_WAIT  = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FLUSH     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_por_last    = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cfg_last    = CNT_W'(CFG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_wdt_last    = CNT_W'(WDT_CYCLES - 1);
    localparam logic [15:0]      c_flush_last  = 16'(FLUSH_CYCLES - 1);
    localparam logic [3:0]       c_settle_last = 4'(SETTLE_FRAMES - 1);

    // Registered state
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_frame_cnt;
    logic [15:0]      r_flush_cnt;
    logic             r_tgt_mode;
    logic             r_cfg_done_q;
    logic             r_gauss_meta;
    logic             r_gauss_sync;
    logic             r_cfg_start;
    logic             r_mode;
    logic             r_gauss;
    logic             r_flush;
    logic             r_running;
    logic [7:0]       r_recover;

    // Next-state values
    state_t           w_state;
    logic [CNT_W-1:0] w_cnt;
    logic [3:0]       w_frame_cnt;
    logic [15:0]      w_flush_cnt;
    logic             w_tgt_mode;
    logic             w_cfg_start;
    logic             w_mode;
    logic             w_gauss;
    logic             w_flush;
    logic             w_running;
    logic [7:0]       w_recover;
    logic [7:0]       w_recover_inc;
    logic             w_wdt_trip;

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_frame_cnt = r_frame_cnt;
        w_flush_cnt = r_flush_cnt;
        w_cfg_start = 1'b0;
        w_mode      = r_mode;
        w_gauss     = r_gauss;
        w_flush     = r_flush;
        w_running   = r_running;
        w_recover   = r_recover;
        w_wdt_trip  = 1'b0;
        // A toggle coincident with a deciding sof is part of that decision.
        w_tgt_mode    = r_tgt_mode ^ i_mode_toggle;
        w_recover_inc = (r_recover == 8'hFF) ? r_recover : r_recover + 8'd1;

        case (r_state)
            ST_IDLE: begin
                w_flush   = 1'b1;
                w_running = 1'b0;
                if (r_cnt == c_por_last) begin
                    w_state     = ST_CFG_START;
                    w_cfg_start = 1'b1;
                    w_cnt       = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            ST_CFG_START: begin
                w_state = ST_CFG_WAIT;
                w_cnt   = '0;
            end

            ST_CFG_WAIT: begin
                // Only a fresh rising edge counts; a level stuck high from a
                // previous attempt must not be mistaken for completion.
                if (i_cfg_done && !r_cfg_done_q) begin
                    w_state     = ST_SETTLE;
                    w_frame_cnt = '0;
                    w_cnt       = '0;
                end else if (r_cnt == c_cfg_last) begin
                    w_recover   = w_recover_inc;
                    w_state     = ST_CFG_START;
                    w_cfg_start = 1'b1;
                    w_cnt       = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            ST_SETTLE: begin
                if (i_sof) begin
                    w_cnt = '0;
                    if (r_frame_cnt == c_settle_last) begin
                        w_state     = ST_RUN;
                        w_mode      = w_tgt_mode;
                        w_gauss     = r_gauss_sync;
                        w_flush     = 1'b0;
                        w_running   = 1'b1;
                        w_frame_cnt = '0;
                    end else begin
                        w_frame_cnt = r_frame_cnt + 1'b1;
                    end
                end else if (r_cnt == c_wdt_last) begin
                    w_wdt_trip = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            ST_RUN: begin
                if (i_sof) begin
                    w_cnt = '0;
                    if ((w_tgt_mode != r_mode) || (r_gauss_sync != r_gauss)) begin
                        w_state     = ST_FLUSH;
                        w_mode      = w_tgt_mode;
                        w_gauss     = r_gauss_sync;
                        w_flush     = 1'b1;
                        w_running   = 1'b0;
                        w_flush_cnt = '0;
                    end
                end else if (r_cnt == c_wdt_last) begin
                    w_wdt_trip = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            ST_FLUSH: begin
                // Flush length has its own counter so that sof pulses, which
                // feed the watchdog, cannot stretch or shorten the flush.
                if (r_flush_cnt == c_flush_last) begin
                    w_state   = ST_RUN;
                    w_flush   = 1'b0;
                    w_running = 1'b1;
                    w_cnt     = '0;
                end else begin
                    w_flush_cnt = r_flush_cnt + 1'b1;
                    if (i_sof) begin
                        w_cnt = '0;
                    end else if (r_cnt == c_wdt_last) begin
                        w_wdt_trip = 1'b1;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state   = ST_IDLE;
                w_cnt     = '0;
                w_flush   = 1'b1;
                w_running = 1'b0;
            end
        endcase

        // Watchdog recovery keeps the last applied mode/Gaussian values.
        if (w_wdt_trip) begin
            w_recover   = w_recover_inc;
            w_flush     = 1'b1;
            w_running   = 1'b0;
            w_state     = ST_CFG_START;
            w_cfg_start = 1'b1;
            w_cnt       = '0;
        end
    end

    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_frame_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_tgt_mode   <= 1'b0;
            r_cfg_done_q <= 1'b0;
            r_gauss_meta <= 1'b0;
            r_gauss_sync <= 1'b0;
            r_cfg_start  <= 1'b0;
            r_mode       <= 1'b0;
            r_gauss      <= 1'b0;
            r_flush      <= 1'b1;
            r_running    <= 1'b0;
            r_recover    <= 8'd0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_frame_cnt  <= w_frame_cnt;
            r_flush_cnt  <= w_flush_cnt;
            r_tgt_mode   <= w_tgt_mode;
            r_cfg_done_q <= i_cfg_done;
            r_gauss_meta <= i_gaussian_req;
            r_gauss_sync <= r_gauss_meta;
            r_cfg_start  <= w_cfg_start;
            r_mode       <= w_mode;
            r_gauss      <= w_gauss;
            r_flush      <= w_flush;
            r_running    <= w_running;
            r_recover    <= w_recover;
        end
    end

    assign o_cfg_start       = r_cfg_start;
    assign o_mode            = r_mode;
    assign o_gaussian_enable = r_gauss;
    assign o_pipe_flush      = r_flush;
    assign o_running         = r_running;
    assign o_state           = r_state;
    assign o_recover_count   = r_recover;

endmodule
`default_nettype wire

// File: tb/tb_pipe_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_sequencer
//  Description : Directed self-checking bench for pipe_sequencer with short
//                timing parameters (POR 10, CFG timeout 100, watchdog 200,
//                flush 4, settle 2 frames).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_sequencer;

    logic       i_sysclk = 1'b0;
    logic       db_rstn  = 1'b0;
    logic       i_sof    = 1'b0;
    logic       i_cfg_done     = 1'b0;
    logic       i_mode_toggle  = 1'b0;
    logic       i_gaussian_req = 1'b0;
    logic       o_cfg_start;
    logic       o_mode;
    logic       o_gaussian_enable;
    logic       o_pipe_flush;
    logic       o_running;
    logic [2:0] o_state;
    logic [7:0] o_recover_count;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_sequencer #(
        .POR_CYCLES    (10),
        .CFG_TIMEOUT   (100),
        .WDT_CYCLES    (200),
        .FLUSH_CYCLES  (4),
        .SETTLE_FRAMES (2),
        .CNT_W         (27)
    ) u_dut (
        .i_sysclk          (i_sysclk),
        .db_rstn           (db_rstn),
        .i_sof             (i_sof),
        .i_cfg_done        (i_cfg_done),
        .i_mode_toggle     (i_mode_toggle),
        .i_gaussian_req    (i_gaussian_req),
        .o_cfg_start       (o_cfg_start),
        .o_mode            (o_mode),
        .o_gaussian_enable (o_gaussian_enable),
        .o_pipe_flush      (o_pipe_flush),
        .o_running         (o_running),
        .o_state           (o_state),
        .o_recover_count   (o_recover_count)
    );

    always #5 i_sysclk = ~i_sysclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge i_sysclk);
        #1;
    endtask

    task automatic sof_pulse();
        i_sof = 1'b1;
        tick();
        i_sof = 1'b0;
    endtask

    task automatic toggle_pulse();
        i_mode_toggle = 1'b1;
        tick();
        i_mode_toggle = 1'b0;
    endtask

    task automatic reset_release();
        db_rstn = 1'b0;
        repeat (2) tick();
        db_rstn = 1'b1;
    endtask

    // Reset, configure and settle into RUN.
    task automatic bring_up();
        i_cfg_done = 1'b0;
        reset_release();
        repeat (15) tick();
        i_cfg_done = 1'b1;
        tick();
        sof_pulse();
        repeat (5) tick();
        sof_pulse();
        check_eq("bringup_state", 32'(o_state), 32'd4);
    endtask

    initial begin
        int pulses;
        int pulse_at;

        // ---------------- Stuck-high configuration done ----------------
        i_cfg_done = 1'b1;
        db_rstn    = 1'b0;
        repeat (2) tick();
        check_eq("rst_state",   32'(o_state),           32'd0);
        check_eq("rst_flush",   32'(o_pipe_flush),      32'd1);
        check_eq("rst_cfg",     32'(o_cfg_start),       32'd0);
        check_eq("rst_running", 32'(o_running),         32'd0);
        check_eq("rst_mode",    32'(o_mode),            32'd0);
        check_eq("rst_gauss",   32'(o_gaussian_enable), 32'd0);
        check_eq("rst_recover", 32'(o_recover_count),   32'd0);
        db_rstn = 1'b1;
        repeat (10) tick();
        check_eq("stuck_cfg_start", 32'(o_cfg_start), 32'd1);
        tick();
        check_eq("stuck_wait", 32'(o_state), 32'd2);
        repeat (99) tick();
        check_eq("stuck_still_wait", 32'(o_state), 32'd2);
        check_eq("stuck_no_recover", 32'(o_recover_count), 32'd0);
        tick();
        check_eq("stuck_timeout_state", 32'(o_state), 32'd1);
        check_eq("stuck_second_start", 32'(o_cfg_start), 32'd1);
        check_eq("stuck_recover", 32'(o_recover_count), 32'd1);

        // ---------------- Power-up sequence ----------------
        i_cfg_done = 1'b0;
        reset_release();
        check_eq("pwr_recover_clr", 32'(o_recover_count), 32'd0);
        pulses   = 0;
        pulse_at = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (o_cfg_start) begin
                pulses++;
                pulse_at = i;
            end
        end
        check_eq("pwr_cfg_pulses", 32'(pulses), 32'd1);
        check_eq("pwr_cfg_cycle", 32'(pulse_at), 32'd10);
        check_eq("pwr_wait", 32'(o_state), 32'd2);
        repeat (18) tick();
        i_cfg_done = 1'b1;
        tick();
        check_eq("pwr_settle", 32'(o_state), 32'd3);
        sof_pulse();
        check_eq("pwr_settle_sof1", 32'(o_state), 32'd3);
        repeat (10) tick();
        check_eq("pwr_flush_pre", 32'(o_pipe_flush), 32'd1);
        sof_pulse();
        check_eq("pwr_run", 32'(o_state), 32'd4);
        check_eq("pwr_flush_off", 32'(o_pipe_flush), 32'd0);
        check_eq("pwr_running", 32'(o_running), 32'd1);

        // ---------------- Mode change in RUN ----------------
        toggle_pulse();
        repeat (49) tick();
        check_eq("mc_no_early", 32'(o_mode), 32'd0);
        check_eq("mc_no_early_flush", 32'(o_pipe_flush), 32'd0);
        sof_pulse();
        check_eq("mc_mode", 32'(o_mode), 32'd1);
        check_eq("mc_state", 32'(o_state), 32'd5);
        check_eq("mc_running", 32'(o_running), 32'd0);
        pulses = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_pipe_flush) pulses++;
        end
        check_eq("mc_flush_len", 32'(pulses), 32'd4);
        check_eq("mc_back_run", 32'(o_state), 32'd4);

        // ---------------- Double toggle, Gaussian ----------------
        toggle_pulse();
        tick();
        toggle_pulse();
        sof_pulse();
        check_eq("dt_no_flush", 32'(o_state), 32'd4);
        check_eq("dt_mode", 32'(o_mode), 32'd1);
        i_gaussian_req = 1'b1;
        repeat (3) tick();
        sof_pulse();
        check_eq("g_state", 32'(o_state), 32'd5);
        check_eq("g_enable", 32'(o_gaussian_enable), 32'd1);
        repeat (4) tick();
        check_eq("g_back_run", 32'(o_state), 32'd4);

        // Toggle coincident with sof is included; pulses in FLUSH retained.
        i_mode_toggle = 1'b1;
        i_sof         = 1'b1;
        tick();
        i_mode_toggle = 1'b0;
        i_sof         = 1'b0;
        check_eq("co_state", 32'(o_state), 32'd5);
        check_eq("co_mode", 32'(o_mode), 32'd0);
        i_mode_toggle = 1'b1;
        i_sof         = 1'b1;
        tick();
        i_mode_toggle = 1'b0;
        i_sof         = 1'b0;
        repeat (3) tick();
        check_eq("fl_ignore_state", 32'(o_state), 32'd4);
        check_eq("fl_ignore_mode", 32'(o_mode), 32'd0);
        sof_pulse();
        check_eq("fl_retained_mode", 32'(o_mode), 32'd1);
        check_eq("fl_retained_state", 32'(o_state), 32'd5);
        repeat (4) tick();

        // ---------------- Watchdog ----------------
        sof_pulse();
        check_eq("wd_pre_state", 32'(o_state), 32'd4);
        repeat (199) tick();
        check_eq("wd_not_yet", 32'(o_running), 32'd1);
        tick();
        check_eq("wd_state", 32'(o_state), 32'd1);
        check_eq("wd_cfg_start", 32'(o_cfg_start), 32'd1);
        check_eq("wd_running", 32'(o_running), 32'd0);
        check_eq("wd_flush", 32'(o_pipe_flush), 32'd1);
        check_eq("wd_recover", 32'(o_recover_count), 32'd1);
        check_eq("wd_mode_hold", 32'(o_mode), 32'd1);
        check_eq("wd_gauss_hold", 32'(o_gaussian_enable), 32'd1);
        // cfg_done stays high, so every retry times out
        repeat (101) tick();
        check_eq("wd_retry_recover", 32'(o_recover_count), 32'd2);
        repeat (26000) tick();
        check_eq("wd_saturate", 32'(o_recover_count), 32'd255);

        // ---------------- Reset mid-FLUSH ----------------
        i_gaussian_req = 1'b0;
        bring_up();
        toggle_pulse();
        sof_pulse();
        tick();
        check_eq("rf_in_flush", 32'(o_state), 32'd5);
        #2;
        db_rstn = 1'b0;
        #1;
        check_eq("rf_state",   32'(o_state),           32'd0);
        check_eq("rf_flush",   32'(o_pipe_flush),      32'd1);
        check_eq("rf_mode",    32'(o_mode),            32'd0);
        check_eq("rf_running", 32'(o_running),         32'd0);
        check_eq("rf_recover", 32'(o_recover_count),   32'd0);
        tick();
        db_rstn = 1'b1;
        repeat (9) tick();
        check_eq("rf_idle", 32'(o_state), 32'd0);
        tick();
        check_eq("rf_restart", 32'(o_cfg_start), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
